tick_scheduler: RTL and testbench
=================================

# tick_scheduler

Programmable tick generator and sequencer for multiplier timing. It replaces free-running power-of-two clock division with a configurable period and a bounded or continuous tick count. It emits single-cycle `tick` enables for downstream logic on the system clock, so no derived clocks are used. Configuration uses a valid/ready handshake; runs are controlled with `start`/`stop`, and a `done` pulse marks completion.

## Interface
- `BITS`, default 8: width of the period register and the phase counter.
- `COUNT_BITS`, default 8: width of the tick-count register.

- `clock`, in, 1: system clock; all state changes on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `cfg_valid`, in, 1: configuration offered.
- `cfg_ready`, out, 1: configuration accepted when `cfg_valid & cfg_ready` at an edge.
- `cfg_period`, in, BITS: period minus one; ticks occur every `cfg_period+1` cycles.
- `cfg_count`, in, COUNT_BITS: number of ticks per run; 0 means continuous.
- `start`, in, 1: begin a run (honoured in ARMED only).
- `stop`, in, 1: abort a run (honoured in RUN only).
- `tick`, out, 1: single-cycle enable.
- `busy`, out, 1: high in RUN.
- `armed`, out, 1: high in ARMED.
- `done`, out, 1: registered single-cycle pulse when a bounded run completes.
- `phase`, out, BITS: current phase counter.
- `ticks_left`, out, COUNT_BITS: remaining ticks; holds 0 in continuous mode.

## Operation
**Registers:** state, `phase`, `period_q`, `count_q`, `ticks_left`, `done`.

**IDLE** (no configuration held)
- `cfg_ready`=1.
- On handshake: `period_q`←`cfg_period`, `count_q`←`cfg_count`, `ticks_left`←`cfg_count`; go to ARMED.
- `start` and `stop` are ignored.

**ARMED**
- `cfg_ready`=1. A handshake reloads all three config registers; state stays ARMED.
- `start` → RUN, with `phase`←0 and `ticks_left`←`count_q`.
- Handshake and `start` in the same cycle: the incoming values are latched and used for this run (`ticks_left`←`cfg_count`).
- `stop` is ignored.

**RUN**
- `cfg_ready`=0.
- `tick` = (state==RUN) && (`phase`==`period_q`). This is combinational from registers only.
- On a non-tick edge: `phase`←`phase`+1.
- On a tick edge:
  - `phase`←0.
  - Bounded mode (`count_q`≠0): `ticks_left`←`ticks_left`−1.
  - If `ticks_left` was 1: go to ARMED and `done`←1.
- `stop` → ARMED at the next edge, with `phase`←0 and no `done`. `ticks_left` freezes at its current value.
- `stop` in the same cycle as the final tick: the tick is still emitted, `done`←1, and the next state is ARMED.
- `stop` in the same cycle as a non-final tick: the tick is emitted, `ticks_left` decrements, the next state is ARMED, and no `done`.

**Arithmetic**
- `phase` never exceeds `period_q`, so no wrap-around is possible.
- `cfg_period`=0 gives a tick on every RUN cycle.
- `cfg_period`=2^BITS−1 gives a period of 2^BITS cycles.
- Continuous mode never leaves RUN except through `stop` or reset.

**Configuration lifetime:** configuration persists across runs. ARMED → `start` repeats the last run.

## Timing
- **Reset values:** state IDLE, `phase`=0, `period_q`=0, `count_q`=0, `ticks_left`=0, `done`=0, `tick`=0, `busy`=0, `armed`=0, `cfg_ready`=1.
- **Reset mid-run:** all outputs take their reset values immediately (asynchronously) and the configuration is lost.
- **Tick latency:**
  - `start` sampled at edge E0; RUN begins after E0.
  - The first `tick` is high during the cycle after edge E0+P, where P=`period_q`.
  - Subsequent ticks follow every P+1 cycles.
- **`done` timing:** high for exactly one cycle, in the cycle after the final tick's edge. `busy` falls in that same cycle.
- **`cfg_ready`:** combinational from state and low throughout RUN. Configuration offered during RUN is held off until the run ends.

## Test plan
- **Config and single run:** reset, handshake `cfg_period`=3, `cfg_count`=2, then `start`.
  - Expected: `tick` in cycles 4 and 8 after `start`; `ticks_left` goes 2→1→0; `done` in cycle 9; state ARMED.
- **Continuous mode:** `cfg_period`=0, `cfg_count`=0, then `start`.
  - Expected: `tick` every cycle for 20 cycles; `ticks_left`=0; no `done`; `stop` → ARMED next cycle with `tick`=0.
- **Abort:** `cfg_period`=4, `cfg_count`=5; `stop` asserted at cycle 7 after `start`.
  - Expected: one tick at cycle 5; `ticks_left`=4 frozen; no `done`.
  - A following `start` gives 5 ticks.
- **Simultaneous events:**
  - `stop` on the final tick: `tick` and `done` both asserted.
  - Config handshake plus `start` in ARMED with `cfg_period`=1: ticks every 2 cycles.
  - `start` in IDLE is ignored.
- **Held-off config:** `cfg_valid` held during RUN.
  - Expected: `cfg_ready`=0 until `done`; the config is accepted in the first ARMED cycle.
- **Reset mid-run and maximum period:**
  - `reset_n` low mid-run: all outputs reset without waiting for a clock edge; state IDLE.
  - `cfg_period`=255 with BITS=8: ticks 256 cycles apart.

Source files
------------

// File: rtl/tick_scheduler_if.sv
// Configuration handshake, run control and tick/status outputs of tick_scheduler.
// The bench or host is the master; the scheduler is the slave.
interface tick_scheduler_if #(
   parameter int BITS       = 8,
   parameter int COUNT_BITS = 8
);
   logic                  cfg_valid;
   logic                  cfg_ready;
   logic [BITS-1:0]       cfg_period;
   logic [COUNT_BITS-1:0] cfg_count;
   logic                  start;
   logic                  stop;
   logic                  tick;
   logic                  busy;
   logic                  armed;
   logic                  done;
   logic [BITS-1:0]       phase;
   logic [COUNT_BITS-1:0] ticks_left;

   modport master (
      output cfg_valid, cfg_period, cfg_count, start, stop,
      input  cfg_ready, tick, busy, armed, done, phase, ticks_left
   );

   modport slave (
      input  cfg_valid, cfg_period, cfg_count, start, stop,
      output cfg_ready, tick, busy, armed, done, phase, ticks_left
   );
endinterface

// File: rtl/tick_scheduler.sv
// Programmable tick sequencer: single-cycle tick enables every period+1 cycles,
// for a bounded tick count or continuously, with a done pulse on completion.
module tick_scheduler #(
   parameter int BITS       = 8,
   parameter int COUNT_BITS = 8
) (
   input logic             clock,
   input logic             reset_n,
   tick_scheduler_if.slave bus
);
   typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_RUN} state_e;

   state_e                state_q, state_d;
   logic [BITS-1:0]       phase_q, phase_d;
   logic [BITS-1:0]       period_q, period_d;
   logic [COUNT_BITS-1:0] count_q, count_d;
   logic [COUNT_BITS-1:0] ticks_left_q, ticks_left_d;
   logic                  done_q, done_d;

   logic cfg_hs;
   logic tick_now;
   logic bounded;
   logic final_tick;

   assign tick_now   = (state_q == ST_RUN) && (phase_q == period_q);
   assign bounded    = (count_q != '0);
   assign final_tick = tick_now && bounded && (ticks_left_q == COUNT_BITS'(1));
   assign cfg_hs     = bus.cfg_valid && (state_q != ST_RUN);

   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      period_d     = period_q;
      count_d      = count_q;
      ticks_left_d = ticks_left_q;
      done_d       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cfg_hs) begin
               period_d     = bus.cfg_period;
               count_d      = bus.cfg_count;
               ticks_left_d = bus.cfg_count;
               state_d      = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (cfg_hs) begin
               period_d     = bus.cfg_period;
               count_d      = bus.cfg_count;
               ticks_left_d = bus.cfg_count;
            end
            // A config arriving with start is the one this run uses.
            if (bus.start) begin
               state_d      = ST_RUN;
               phase_d      = '0;
               ticks_left_d = cfg_hs ? bus.cfg_count : count_q;
            end
         end
         ST_RUN: begin
            if (tick_now) begin
               phase_d = '0;
               if (bounded) ticks_left_d = ticks_left_q - COUNT_BITS'(1);
            end else begin
               phase_d = phase_q + BITS'(1);
            end
            // The final tick wins over stop so that done is still reported.
            if (final_tick) begin
               state_d = ST_ARMED;
               done_d  = 1'b1;
            end else if (bus.stop) begin
               state_d = ST_ARMED;
               phase_d = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         phase_q      <= '0;
         period_q     <= '0;
         count_q      <= '0;
         ticks_left_q <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         period_q     <= period_d;
         count_q      <= count_d;
         ticks_left_q <= ticks_left_d;
         done_q       <= done_d;
      end
   end

   assign bus.cfg_ready  = (state_q != ST_RUN);
   assign bus.tick       = tick_now;
   assign bus.busy       = (state_q == ST_RUN);
   assign bus.armed      = (state_q == ST_ARMED);
   assign bus.done       = done_q;
   assign bus.phase      = phase_q;
   assign bus.ticks_left = ticks_left_q;
endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: directed scenarios plus random stimulus, all checked
// against a run-time arithmetic model (ticks at run cycle k where k mod (P+1) == P).
module tb_tick_scheduler;
   localparam int BITS = 8;
   localparam int CB   = 8;
   localparam int VW   = 5 + BITS + CB;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int   vecs = 0;
   int   errs = 0;

   tick_scheduler_if #(.BITS(BITS), .COUNT_BITS(CB)) bus();

   tick_scheduler #(.BITS(BITS), .COUNT_BITS(CB)) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   // Model: mode 0 idle, 1 armed, 2 running; m_k counts cycles since the run began.
   int m_st, m_per, m_cnt, m_k, m_left;
   bit m_done;

   function automatic bit m_tick();
      return (m_st == 2) && ((m_k % (m_per + 1)) == m_per);
   endfunction

   function automatic int m_tl();
      if (m_st != 2) return m_left;
      if (m_cnt == 0) return 0;
      return m_cnt - m_k / (m_per + 1);
   endfunction

   function automatic logic [VW-1:0] exp_vec();
      logic [BITS-1:0] ph;
      logic [CB-1:0]   tl;
      ph = (m_st == 2) ? BITS'(m_k % (m_per + 1)) : '0;
      tl = CB'(m_tl());
      return {m_tick(), m_done, m_st == 2, m_st == 1, m_st != 2, ph, tl};
   endfunction

   function automatic logic [VW-1:0] obs_vec();
      return {bus.tick, bus.done, bus.busy, bus.armed, bus.cfg_ready, bus.phase, bus.ticks_left};
   endfunction

   task automatic model_reset();
      m_st = 0; m_per = 0; m_cnt = 0; m_k = 0; m_left = 0; m_done = 0;
   endtask

   task automatic quiet();
      bus.cfg_valid = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
   endtask

   // Advance the model by one edge using the inputs currently driven, then clock.
   task automatic adv();
      bit hs, tk;
      int tl;
      hs = bus.cfg_valid && (m_st != 2);
      tk = m_tick();
      tl = m_tl();
      m_done = 0;
      case (m_st)
         0: if (hs) begin m_per = int'(bus.cfg_period); m_cnt = int'(bus.cfg_count); m_left = m_cnt; m_st = 1; end
         1: begin
            if (hs) begin m_per = int'(bus.cfg_period); m_cnt = int'(bus.cfg_count); m_left = m_cnt; end
            if (bus.start) begin m_st = 2; m_k = 0; end
         end
         default: begin
            if (tk && m_cnt != 0 && tl == 1) begin m_st = 1; m_done = 1; m_left = 0; end
            else if (bus.stop) begin m_st = 1; m_left = (m_cnt == 0) ? 0 : tl - (tk ? 1 : 0); end
            else m_k++;
         end
      endcase
      @(posedge clock); #1;
   endtask

   task automatic cfg_drive(input int per, input int cnt);
      bus.cfg_valid = 1'b1; bus.cfg_period = BITS'(per); bus.cfg_count = CB'(cnt);
   endtask

   task automatic test_reset();
      quiet(); bus.cfg_period = '0; bus.cfg_count = '0;
      reset_n = 1'b0; model_reset();
      #3;
      if (obs_vec() !== exp_vec()) begin errs++; $display("FAIL reset_values: got %h want %h", obs_vec(), exp_vec()); end
      vecs++;
      @(posedge clock); #1; reset_n = 1'b1;
      bus.start = 1'b1; bus.stop = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (obs_vec() !== exp_vec()) begin errs++; $display("FAIL idle_start_ignored[%0d]: got %h want %h", i, obs_vec(), exp_vec()); end
         vecs++;
         adv();
      end
      quiet();
   endtask

   task automatic test_single_run();
      int t1, t2, d, nt;
      t1 = -1; t2 = -1; d = -1; nt = 0;
      cfg_drive(3, 2); adv(); quiet();
      bus.start = 1'b1; adv(); bus.start = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         if (obs_vec() !== exp_vec()) begin errs++; $display("FAIL single_run cyc%0d: got %h want %h", n, obs_vec(), exp_vec()); end
         vecs++;
         if (bus.tick) begin nt++; if (t1 < 0) t1 = n; else t2 = n; end
         if (bus.done) d = n;
         adv();
      end
      if (t1 !== 4 || t2 !== 8 || d !== 9 || nt !== 2) begin
         errs++; $display("FAIL single_run_timing: ticks %0d@%0d,%0d done@%0d want 2@4,8 done@9", nt, t1, t2, d);
      end
      vecs++;
      if (bus.armed !== 1'b1 || bus.ticks_left !== CB'(0)) begin
         errs++; $display("FAIL single_run_end: armed %b left %0d want 1 0", bus.armed, bus.ticks_left);
      end
      vecs++;
   endtask

   task automatic test_continuous();
      int nt, nd;
      nt = 0; nd = 0;
      cfg_drive(0, 0); adv(); quiet();
      bus.start = 1'b1; adv(); bus.start = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         if (obs_vec() !== exp_vec()) begin errs++; $display("FAIL continuous cyc%0d: got %h want %h", n, obs_vec(), exp_vec()); end
         vecs++;
         nt += int'(bus.tick); nd += int'(bus.done);
         adv();
      end
      if (nt !== 20 || nd !== 0) begin errs++; $display("FAIL continuous_count: ticks %0d done %0d want 20 0", nt, nd); end
      vecs++;
      bus.stop = 1'b1; adv(); bus.stop = 1'b0;
      if (bus.armed !== 1'b1 || bus.tick !== 1'b0 || bus.done !== 1'b0) begin
         errs++; $display("FAIL continuous_stop: armed %b tick %b done %b want 1 0 0", bus.armed, bus.tick, bus.done);
      end
      vecs++;
   endtask

   task automatic test_abort();
      int nt, nd, t1;
      nt = 0; nd = 0; t1 = -1;
      cfg_drive(4, 5); adv(); quiet();
      bus.start = 1'b1; adv(); bus.start = 1'b0;
      for (int n = 1; n <= 7; n++) begin
         bus.stop = (n == 7);
         if (obs_vec() !== exp_vec()) begin errs++; $display("FAIL abort cyc%0d: got %h want %h", n, obs_vec(), exp_vec()); end
         vecs++;
         if (bus.tick) begin nt++; if (t1 < 0) t1 = n; end
         adv();
      end
      bus.stop = 1'b0;
      for (int n = 0; n < 3; n++) begin
         nd += int'(bus.done);
         if (obs_vec() !== exp_vec()) begin errs++; $display("FAIL abort_hold%0d: got %h want %h", n, obs_vec(), exp_vec()); end
         vecs++;
         adv();
      end
      if (nt !== 1 || t1 !== 5 || bus.ticks_left !== CB'(4) || nd !== 0) begin
         errs++; $display("FAIL abort_result: ticks %0d@%0d left %0d done %0d want 1@5 4 0", nt, t1, bus.ticks_left, nd);
      end
      vecs++;
      nt = 0; nd = 0;
      bus.start = 1'b1; adv(); bus.start = 1'b0;
      for (int n = 1; n <= 40 && nd == 0; n++) begin
         if (obs_vec() !== exp_vec()) begin errs++; $display("FAIL rerun cyc%0d: got %h want %h", n, obs_vec(), exp_vec()); end
         vecs++;
         nt += int'(bus.tick); nd += int'(bus.done);
         adv();
      end
      if (nt !== 5 || nd !== 1) begin errs++; $display("FAIL rerun_count: ticks %0d done %0d want 5 1", nt, nd); end
      vecs++;
   endtask

   task automatic test_simultaneous();
      int nt, d;
      cfg_drive(1, 2); adv(); quiet();
      bus.start = 1'b1; adv(); bus.start = 1'b0;
      for (int n = 1; n <= 5; n++) begin
         bus.stop = (n == 4);
         if (obs_vec() !== exp_vec()) begin errs++; $display("FAIL stop_final cyc%0d: got %h want %h", n, obs_vec(), exp_vec()); end
         vecs++;
         if (n == 4 && bus.tick !== 1'b1) begin errs++; $display("FAIL stop_final_tick: got %b want 1", bus.tick); end
         if (n == 5 && (bus.done !== 1'b1 || bus.armed !== 1'b1)) begin
            errs++; $display("FAIL stop_final_done: done %b armed %b want 1 1", bus.done, bus.armed);
         end
         if (n >= 4) vecs++;
         adv();
      end
      bus.stop = 1'b0;
      // Reconfigure and start in the same ARMED cycle.
      nt = 0; d = -1;
      cfg_drive(1, 3); bus.start = 1'b1; adv(); quiet();
      for (int n = 1; n <= 8; n++) begin
         if (obs_vec() !== exp_vec()) begin errs++; $display("FAIL cfg_start cyc%0d: got %h want %h", n, obs_vec(), exp_vec()); end
         vecs++;
         if (bus.tick && (n % 2) == 0) nt++;
         if (bus.done) d = n;
         adv();
      end
      if (nt !== 3 || d !== 7) begin errs++; $display("FAIL cfg_start_timing: even ticks %0d done@%0d want 3 7", nt, d); end
      vecs++;
   endtask

   task automatic test_holdoff();
      int held, acc;
      held = 0; acc = 0;
      cfg_drive(2, 1); adv(); quiet();
      bus.start = 1'b1; adv(); bus.start = 1'b0;
      cfg_drive(5, 7);
      for (int n = 1; n <= 10 && acc == 0; n++) begin
         if (obs_vec() !== exp_vec()) begin errs++; $display("FAIL holdoff cyc%0d: got %h want %h", n, obs_vec(), exp_vec()); end
         vecs++;
         if (bus.busy && bus.cfg_ready !== 1'b0) held++;
         if (bus.done) begin
            acc = 1;
            if (bus.cfg_ready !== 1'b1 || n !== 4) begin
               errs++; $display("FAIL holdoff_accept: ready %b at cyc%0d want 1 at 4", bus.cfg_ready, n);
            end
            vecs++;
         end
         adv();
      end
      bus.cfg_valid = 1'b0;
      if (held !== 0 || acc !== 1 || bus.ticks_left !== CB'(7)) begin
         errs++; $display("FAIL holdoff_result: early-ready %0d accepted %0d left %0d want 0 1 7", held, acc, bus.ticks_left);
      end
      vecs++;
   endtask

   task automatic test_maxperiod_and_reset();
      int t1, t2, d;
      t1 = -1; t2 = -1; d = -1;
      cfg_drive(255, 2); adv(); quiet();
      bus.start = 1'b1; adv(); bus.start = 1'b0;
      for (int n = 1; n <= 520 && d < 0; n++) begin
         if (obs_vec() !== exp_vec()) begin errs++; $display("FAIL maxper cyc%0d: got %h want %h", n, obs_vec(), exp_vec()); end
         vecs++;
         if (bus.tick) begin if (t1 < 0) t1 = n; else t2 = n; end
         if (bus.done) d = n;
         adv();
      end
      if (t1 !== 256 || t2 !== 512 || d !== 513) begin
         errs++; $display("FAIL maxper_timing: ticks@%0d,%0d done@%0d want 256,512 513", t1, t2, d);
      end
      vecs++;
      cfg_drive(10, 0); adv(); quiet();
      bus.start = 1'b1; adv(); bus.start = 1'b0;
      for (int n = 0; n < 7; n++) adv();
      #2; reset_n = 1'b0; model_reset();
      #1;
      if (obs_vec() !== exp_vec()) begin errs++; $display("FAIL async_reset: got %h want %h", obs_vec(), exp_vec()); end
      vecs++;
      @(posedge clock); #1; reset_n = 1'b1;
      bus.start = 1'b1;
      if (obs_vec() !== exp_vec()) begin errs++; $display("FAIL post_reset_idle: got %h want %h", obs_vec(), exp_vec()); end
      vecs++;
      adv(); bus.start = 1'b0;
      if (obs_vec() !== exp_vec()) begin errs++; $display("FAIL config_lost: got %h want %h", obs_vec(), exp_vec()); end
      vecs++;
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         bus.cfg_valid  = ($urandom_range(0, 9) < 3);
         bus.cfg_period = BITS'($urandom_range(0, 5));
         bus.cfg_count  = CB'($urandom_range(0, 4));
         bus.start      = ($urandom_range(0, 9) < 2);
         bus.stop       = ($urandom_range(0, 19) == 0);
         if (obs_vec() !== exp_vec()) begin errs++; $display("FAIL random[%0d]: got %h want %h", n, obs_vec(), exp_vec()); end
         vecs++;
         adv();
      end
      quiet();
   endtask

   initial begin
      test_reset();
      test_single_run();
      test_continuous();
      test_abort();
      test_simultaneous();
      test_holdoff();
      test_maxperiod_and_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
